// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// The request record captures everything latched from the winning port at grant time.
package sram_arb_pkg;

    localparam int ARB_ADDR_W = 20;
    localparam int ARB_DATA_W = 16;
    localparam int CNT_W      = 4;

    localparam logic CPU_PORT = 1'b0;
    localparam logic AUX_PORT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection: round-robin on a tie, or fixed CPU priority
// when SRAM_ARB_CPU_PRIORITY_EN is defined.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic any_req,
    output logic winner
);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // decision tree can leave one unassigned and infer a latch.
        any_req = req0 | req1;
        winner  = CPU_PORT;
        if (req0 && req1) begin
`ifdef SRAM_ARB_CPU_PRIORITY_EN
            winner = CPU_PORT;
`else
            winner = ~last_served;
`endif
        end else if (req1) begin
            winner = AUX_PORT;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external 1Mx16 SRAM: latches the winning request,
// then sequences SETUP, a WAIT_CYCLES strobe window and a DONE hold cycle.
// Tie policy is selected by the SRAM_ARB_CPU_PRIORITY_EN macro (see sram_arb_pick).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              data_oe,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
    end
    if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W) begin : g_bad_width
        $error("sram_arbiter: ADDR_W/DATA_W must match sram_arb_pkg widths");
    end

    state_t           state, state_nx;
    req_t             cur;
    logic [CNT_W-1:0] cnt;
    logic             win_q;
    logic             last_served;
    logic             any_req;
    logic             pick_win;

    sram_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served),
        .any_req     (any_req),
        .winner      (pick_win)
    );

    // ADDR and write data come straight from the latched request, so they
    // stay put through DONE regardless of what the requesters do meanwhile.
    assign ADDR         = cur.addr;
    assign Data_to_SRAM = cur.wdata;

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values and the update order inside this block is irrelevant.
        if (Reset) begin
            state       <= IDLE;
            cur         <= '0;
            cnt         <= '0;
            win_q       <= CPU_PORT;
            last_served <= AUX_PORT;
            rdata       <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        win_q <= pick_win;
                        cur   <= pick_win ? '{we: we1, addr: addr1, wdata: wdata1}
                                          : '{we: we0, addr: addr0, wdata: wdata0};
                    end
                end
                SETUP: cnt <= CNT_W'(WAIT_CYCLES - 1);
                ACCESS: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0 && !cur.we) begin
                        rdata <= Data_from_SRAM;
                    end
                end
                DONE: last_served <= win_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        CE       = 1'b1;
        UB       = 1'b1;
        LB       = 1'b1;
        OE       = 1'b1;
        WE       = 1'b1;
        data_oe  = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;

        if (state != IDLE) begin
            CE   = 1'b0;
            UB   = 1'b0;
            LB   = 1'b0;
            gnt0 = (win_q == CPU_PORT);
            gnt1 = (win_q == AUX_PORT);
        end

        unique case (state)
            IDLE: begin
                if (any_req) state_nx = SETUP;
            end
            SETUP: state_nx = ACCESS;
            ACCESS: begin
                OE      = cur.we;
                WE      = ~cur.we;
                data_oe = cur.we;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                done0    = (win_q == CPU_PORT);
                done1    = (win_q == AUX_PORT);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a cycle-timeline reference model.
module tb_sram_arbiter;

    localparam int WAIT = 2;
`ifdef SRAM_ARB_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam logic [9:0] IDLE_PINS = 10'b11111_00000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  r = '0;
    logic [1:0]  w = '0;
    logic [19:0] a [2];
    logic [15:0] d [2];
    logic        gnt0, gnt1, done0, done1, data_oe, CE, UB, LB, OE, WE;
    logic [15:0] rdata, Data_to_SRAM;
    logic [15:0] Data_from_SRAM = '0;
    logic [19:0] ADDR;

    int errors = 0;
    int checks = 0;

    logic [15:0] sram_mem [logic [19:0]];
    logic [15:0] exp_mem  [logic [19:0]];

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(WAIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(r[0]), .req1(r[1]), .we0(w[0]), .we1(w[1]),
        .addr0(a[0]), .addr1(a[1]), .wdata0(d[0]), .wdata1(d[1]),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
        .Data_from_SRAM(Data_from_SRAM), .data_oe(data_oe),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [19:0] addr);
        return addr[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [19:0] addr);
        return exp_mem.exists(addr) ? exp_mem[addr] : dflt(addr);
    endfunction

    function automatic logic [9:0] pins();
        return {CE, UB, LB, OE, WE, data_oe, gnt0, gnt1, done0, done1};
    endfunction

    // Expected pin pattern p cycles after the IDLE cycle that accepted a request.
    function automatic logic [9:0] exp_pins(input int p, input logic win, input logic we);
        logic act;
        logic fin;
        act = (p >= 2 && p <= WAIT + 1);
        fin = (p == WAIT + 2);
        if (p == 0) return IDLE_PINS;
        return {3'b000, !(act && !we), !(act && we), act && we,
                win == 1'b0, win == 1'b1, fin && win == 1'b0, fin && win == 1'b1};
    endfunction

    // Advance one clock; the SRAM model writes on WE low and answers reads on ADDR.
    task automatic tick();
        if (CE === 1'b0 && WE === 1'b0) sram_mem[ADDR] = Data_to_SRAM;
        @(posedge Clk);
        #1;
        Data_from_SRAM = sram_mem.exists(ADDR) ? sram_mem[ADDR] : dflt(ADDR);
    endtask

    task automatic clear_inputs();
        r = '0; w = '0;
        a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Follow one transaction from the accepting IDLE cycle through done.
    task automatic run_txn(input string name, input logic exp_win, input logic exp_we,
                           input logic [19:0] exp_addr, input logic [15:0] exp_wd,
                           input logic chk_rd, input logic [15:0] exp_rdata);
        int n_oe = 0, n_we = 0, bad_doe = 0, bad_addr = 0, lat = -1;
        logic got_win = 1'b0;
        for (int tk = 1; tk <= 20 && lat < 0; tk++) begin
            tick();
            if (OE === 1'b0) n_oe++;
            if (WE === 1'b0) n_we++;
            if (data_oe !== !WE) bad_doe++;
            if (WE === 1'b0 && Data_to_SRAM !== exp_wd) bad_doe++;
            if (CE === 1'b0 && ADDR !== exp_addr) bad_addr++;
            if (done0 === 1'b1 || done1 === 1'b1) begin
                lat     = tk;
                got_win = done1;
                if (chk_rd) check($sformatf("%s_rdata", name), rdata, exp_rdata);
            end
        end
        check($sformatf("%s_latency", name), lat, WAIT + 2);
        check($sformatf("%s_winner", name), got_win, exp_win);
        check($sformatf("%s_oe_cycles", name), n_oe, exp_we ? 0 : WAIT);
        check($sformatf("%s_we_cycles", name), n_we, exp_we ? WAIT : 0);
        check($sformatf("%s_data_oe", name), bad_doe, 0);
        check($sformatf("%s_addr", name), bad_addr, 0);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [19:0] a0, a1;
        logic [15:0] d0, d1;
        logic        exp_win;
        logic        chk_rd;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic run_table();
        vec_t vt [8];
        vt[0] = '{2'b01, 2'b01, 20'h00123, 20'h0,     16'hBEEF, 16'h0,    1'b0, 1'b0, 16'h0};
        vt[1] = '{2'b10, 2'b00, 20'h0,     20'h00123, 16'h0,    16'h0,    1'b1, 1'b1, 16'hBEEF};
        vt[2] = '{2'b11, 2'b00, 20'h00123, 20'h00050, 16'h0,    16'h0,    1'b0, 1'b1, 16'hBEEF};
        vt[3] = '{2'b11, 2'b00, 20'h00123, 20'h00050, 16'h0,    16'h0,    !PRIO, 1'b1,
                  PRIO ? 16'hBEEF : 16'h5A0A};
        vt[4] = '{2'b10, 2'b10, 20'h0,     20'hFFFFF, 16'h0,    16'h1234, 1'b1, 1'b0, 16'h0};
        vt[5] = '{2'b01, 2'b00, 20'hFFFFF, 20'h0,     16'h0,    16'h0,    1'b0, 1'b1, 16'h1234};
        vt[6] = '{2'b11, 2'b11, 20'h00050, 20'h00123, 16'hAAAA, 16'h5555, !PRIO, 1'b0, 16'h0};
        vt[7] = '{2'b01, 2'b00, 20'h00123, 20'h0,     16'h0,    16'h0,    1'b0, 1'b1,
                  PRIO ? 16'hBEEF : 16'h5555};
        for (int i = 0; i < 8; i++) begin
            r = vt[i].req; w = vt[i].we;
            a[0] = vt[i].a0; a[1] = vt[i].a1; d[0] = vt[i].d0; d[1] = vt[i].d1;
            run_txn($sformatf("vec%0d", i), vt[i].exp_win, vt[i].we[vt[i].exp_win],
                    vt[i].exp_win ? vt[i].a1 : vt[i].a0,
                    vt[i].exp_win ? vt[i].d1 : vt[i].d0,
                    vt[i].chk_rd, vt[i].exp_rdata);
            r = '0;
            tick();
        end
    endtask

    task automatic run_tie();
        logic order [4];
        int   n = 0;
        reset_dut();
        a[0] = 20'h00001; a[1] = 20'h00002; r = 2'b11;
        for (int tk = 0; tk < 40 && n < 4; tk++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1) begin
                order[n] = done1;
                n++;
            end
        end
        r = '0;
        tick();
        check("tie_count", n, 4);
        for (int i = 0; i < n; i++)
            check($sformatf("tie_order%0d", i), order[i], PRIO ? 1'b0 : logic'(i % 2));
    endtask

    task automatic run_reset_mid();
        int n_done = 0;
        r[0] = 1'b1; w[0] = 1'b1; a[0] = 20'h00777; d[0] = 16'h1111;
        tick();
        tick();
        check("rstmid_we_low", WE, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        clear_inputs();
        check("rstmid_pins", pins(), IDLE_PINS);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1) n_done++;
        end
        check("rstmid_no_done", n_done, 0);
        r[1] = 1'b1; a[1] = 20'h00004;
        run_txn("post_rst", 1'b1, 1'b0, 20'h00004, 16'h0, 1'b1, dflt(20'h00004));
        r = '0;
        tick();
    endtask

    task automatic run_input_change();
        int bad = 0, seen = 0;
        r[0] = 1'b1; w[0] = 1'b0; a[0] = 20'h00010;
        tick();
        tick();
        a[0] = 20'h00020; w[0] = 1'b1; d[0] = 16'hDEAD;
        for (int tk = 0; tk < 20 && seen == 0; tk++) begin
            if (ADDR !== 20'h00010 || WE !== 1'b1) bad++;
            if (done0 === 1'b1) seen = 1;
            else tick();
        end
        check("chg_addr_held", bad, 0);
        check("chg_done", seen, 1);
        check("chg_rdata", rdata, dflt(20'h00010));
        r = '0;
        tick();
    endtask

    task automatic new_fields(input int i);
        w[i] = 1'($urandom_range(0, 1));
        a[i] = {2'($urandom_range(0, 3)), 15'd0, 3'($urandom_range(0, 7))};
        d[i] = 16'($urandom);
    endtask

    task automatic run_random();
        int          m_p = 0;
        logic        m_win = 1'b0, m_last = 1'b1, m_we = 1'b0;
        logic [19:0] m_addr = '0;
        logic [15:0] m_wd = '0, m_rdata = '0;
        reset_dut();
        exp_mem.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rand_pins", pins(), exp_pins(m_p, m_win, m_we));
            check("rand_rdata", rdata, m_rdata);
            if (m_p > 0) check("rand_addr", ADDR, m_addr);
            for (int i = 0; i < 2; i++) begin
                if (m_p == WAIT + 2 && m_win == 1'(i)) begin
                    r[i] = 1'($urandom_range(0, 1));
                    new_fields(i);
                end else if (!r[i]) begin
                    r[i] = ($urandom_range(0, 2) == 0);
                    if (r[i]) new_fields(i);
                end else if (m_p > 0 && m_win == 1'(i)) begin
                    new_fields(i);
                end
            end
            if (m_p == 0) begin
                if (r != 2'b00) begin
                    m_win  = (r == 2'b11) ? (PRIO ? 1'b0 : !m_last) : r[1];
                    m_we   = w[m_win];
                    m_addr = a[m_win];
                    m_wd   = d[m_win];
                    m_p    = 1;
                end
            end else if (m_p == WAIT + 1) begin
                if (!m_we) m_rdata = exp_rd(m_addr);
                m_p++;
            end else if (m_p == WAIT + 2) begin
                if (m_we) exp_mem[m_addr] = m_wd;
                m_last = m_win;
                m_p    = 0;
            end else begin
                m_p++;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_dut();
        check("rst_rdata", rdata, 16'h0);
        check("rst_addr", ADDR, 20'h0);
        check("rst_wdata", Data_to_SRAM, 16'h0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle_pins%0d", i), pins(), IDLE_PINS);
            tick();
        end
        run_table();
        run_tie();
        run_reset_mid();
        run_input_change();
        run_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
